// File: rtl/prog_lut_pkg.sv
// Shared types and constants for the programmable LUT evaluator.
package prog_lut_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SWEEP
   } state_t;

   localparam int N_IN_DEF  = 4;
   localparam int N_OUT_DEF = 1;

   function automatic int depth(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/prog_lut_table.sv
// DEPTH x N_OUT truth-table storage: one write port, one
// combinational read port, asynchronous clear.
module prog_lut_table
   import prog_lut_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int N_OUT = N_OUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [N_IN-1:0]  waddr,
   input  logic [N_OUT-1:0] wdata,
   input  logic [N_IN-1:0]  raddr,
   output logic [N_OUT-1:0] rdata
);

   localparam int DEPTH = depth(N_IN);

   logic [N_OUT-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prog_lut_eval.sv
// Programmable N_IN-input / N_OUT-channel boolean evaluator with
// serial table load, per-request eval and exhaustive sweep.
module prog_lut_eval
   import prog_lut_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int N_OUT = N_OUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_start,
   input  logic                      cfg_valid,
   input  logic [N_OUT-1:0]          cfg_bit,
   output logic                      cfg_done,
   input  logic                      in_valid,
   input  logic [N_IN-1:0]           in_vec,
   output logic                      in_ready,
   input  logic                      sweep_start,
   output logic                      sweep_busy,
   output logic                      sweep_done,
   output logic                      out_valid,
   output logic [N_IN-1:0]           out_idx,
   output logic [N_OUT-1:0]          out_vec,
   input  logic                      out_ready,
   output logic [N_OUT*(N_IN+1)-1:0] ones_count
);

   localparam int CW = N_IN + 1;
   localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

   state_t           state_q, state_d;
   logic [N_IN-1:0]  ptr;
   logic [N_IN-1:0]  raddr;
   logic [N_OUT-1:0] rdata;
   logic             load_we;
   logic             accept;
   logic             sweep_go;
   logic             sweep_adv;
   logic             sweep_last;

   prog_lut_table #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT)
   ) u_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (load_we),
      .waddr (ptr),
      .wdata (cfg_bit),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign in_ready = rst_n && (state_q == IDLE)
                     && (!out_valid || out_ready)
                     && !cfg_start && !sweep_start;

   assign sweep_busy = (state_q == SWEEP);

   always_comb begin
      state_d    = state_q;
      load_we    = 1'b0;
      accept     = 1'b0;
      sweep_go   = 1'b0;
      sweep_adv  = 1'b0;
      sweep_last = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = LOAD;
            end else if (sweep_start && !out_valid) begin
               state_d  = SWEEP;
               sweep_go = 1'b1;
            end else if (in_valid && in_ready) begin
               accept = 1'b1;
            end
         end
         LOAD: begin
            if (cfg_valid) begin
               load_we = 1'b1;
               if (ptr == LAST) state_d = IDLE;
            end
         end
         SWEEP: begin
            if (out_ready) begin
               if (out_idx == LAST) begin
                  state_d    = IDLE;
                  sweep_last = 1'b1;
               end else begin
                  sweep_adv = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // out_idx doubles as the sweep counter
   always_comb begin
      raddr = in_vec;
      if (sweep_adv)     raddr = out_idx + N_IN'(1);
      else if (sweep_go) raddr = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr        <= '0;
         cfg_done   <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_done   <= load_we && (ptr == LAST);
         sweep_done <= sweep_last;
         if (load_we) ptr <= ptr + N_IN'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_vec   <= '0;
      end else if (sweep_go || sweep_adv || accept) begin
         out_valid <= 1'b1;
         out_idx   <= raddr;
         out_vec   <= rdata;
      end else if (sweep_last) begin
         out_valid <= 1'b0;
      end else if (out_valid && out_ready && state_q != SWEEP) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_count <= '0;
      end else if (sweep_go) begin
         ones_count <= '0;
      end else if (sweep_adv || sweep_last) begin
         for (int k = 0; k < N_OUT; k++) begin
            ones_count[k*CW +: CW] <= ones_count[k*CW +: CW]
                                      + CW'(out_vec[k]);
         end
      end
   end

endmodule

// File: tb/tb_prog_lut_eval.sv
// Scoreboard bench for prog_lut_eval: parity table on channel 0,
// 4-input AND on channel 1.
module tb_prog_lut_eval;

   localparam int N_IN  = 4;
   localparam int N_OUT = 2;
   localparam int CW    = N_IN + 1;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic                      cfg_start = 1'b0;
   logic                      cfg_valid = 1'b0;
   logic [N_OUT-1:0]          cfg_bit = '0;
   logic                      cfg_done;
   logic                      in_valid = 1'b0;
   logic [N_IN-1:0]           in_vec = '0;
   logic                      in_ready;
   logic                      sweep_start = 1'b0;
   logic                      sweep_busy;
   logic                      sweep_done;
   logic                      out_valid;
   logic [N_IN-1:0]           out_idx;
   logic [N_OUT-1:0]          out_vec;
   logic                      out_ready = 1'b1;
   logic [N_OUT*CW-1:0]       ones_count;

   int checks = 0;
   int errors = 0;
   int cfg_done_n = 0;
   int sweep_done_n = 0;
   logic [15:0] t0;
   logic [15:0] t1;
   logic [N_IN+N_OUT-1:0] exp_q[$];

   prog_lut_eval #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_start   (cfg_start),
      .cfg_valid   (cfg_valid),
      .cfg_bit     (cfg_bit),
      .cfg_done    (cfg_done),
      .in_valid    (in_valid),
      .in_vec      (in_vec),
      .in_ready    (in_ready),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done),
      .out_valid   (out_valid),
      .out_idx     (out_idx),
      .out_vec     (out_vec),
      .out_ready   (out_ready),
      .ones_count  (ones_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [N_IN+N_OUT-1:0] expv(input logic [3:0] v);
      return {v, t1[v], t0[v]};
   endfunction

   always @(negedge clk) begin
      if (cfg_done) cfg_done_n++;
      if (sweep_done) sweep_done_n++;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", {out_idx, out_vec}, '0);
            if ({out_idx, out_vec} == '0) begin
               errors++;
               $display("FAIL unexpected_result: got idx %0d with empty queue",
                        out_idx);
            end
         end else begin
            chk("result", {out_idx, out_vec}, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_bits(input logic [15:0] a, input logic [15:0] b);
      for (int i = 0; i < 16; i++) begin
         if (i == 3 || i == 7 || i == 12) begin
            cfg_valid = 1'b0;
            tick();
         end
         cfg_valid = 1'b1;
         cfg_bit   = {b[i], a[i]};
         tick();
      end
      cfg_valid = 1'b0;
      chk("cfg_done_pulse", cfg_done, 1);
      tick();
      chk("cfg_done_low", cfg_done, 0);
   endtask

   task automatic start_load();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic eval(input logic [3:0] v);
      bit ok = 0;
      in_valid = 1'b1;
      in_vec   = v;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      chk("in_ready_wait", ok, 1);
      if (ok) exp_q.push_back(expv(v));
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int sd0;
      t0 = 16'h6996;
      t1 = 16'h8000;

      #2 rst_n = 1'b0;
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      tick();
      start_load();
      cfg_valid = 1'b1;
      cfg_bit   = 2'b11;
      repeat (8) tick();
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      #1;
      chk("midload_rst_outs", {out_valid, out_idx, out_vec, cfg_done,
                               sweep_busy, sweep_done, in_ready}, 0);
      chk("midload_rst_ones", ones_count, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midload_rst_ready", in_ready, 1);
      chk("midload_no_done", cfg_done_n, 0);
      tick();
      eval(4'd5);
      tick();

      start_load();
      load_bits(t0, t1);
      chk("cfg_done_count", cfg_done_n, 1);

      eval(4'b1011);
      eval(4'b0011);
      tick();

      out_ready = 1'b0;
      eval(4'd11);
      in_valid = 1'b1;
      in_vec   = 4'd3;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_hold", {out_valid, out_idx, out_vec}, {1'b1, expv(4'd11)});
         tick();
      end
      out_ready = 1'b1;
      eval(4'd3);
      eval(4'd6);
      tick();
      tick();
      chk("bp_queue_empty", exp_q.size(), 0);

      sd0 = sweep_done_n;
      sweep_start = 1'b1;
      for (int i = 0; i < 16; i++) exp_q.push_back(expv(4'(i)));
      tick();
      sweep_start = 1'b0;
      chk("sweep_busy", sweep_busy, 1);
      for (int n = 0; n < 100; n++) begin
         if (sweep_done_n != sd0) break;
         out_ready = ~out_ready;
         tick();
      end
      out_ready = 1'b1;
      chk("sweep_done_count", sweep_done_n - sd0, 1);
      chk("sweep_queue_empty", exp_q.size(), 0);
      chk("sweep_ones", ones_count, {5'd1, 5'd8});
      chk("sweep_end_state", {sweep_busy, out_valid}, 0);

      tick();
      cfg_start   = 1'b1;
      sweep_start = 1'b1;
      in_valid    = 1'b1;
      in_vec      = 4'd2;
      @(negedge clk);
      chk("prio_in_ready", in_ready, 0);
      tick();
      cfg_start   = 1'b0;
      sweep_start = 1'b0;
      in_valid    = 1'b0;
      @(negedge clk);
      chk("prio_no_sweep", {sweep_busy, out_valid}, 0);
      tick();
      load_bits(t0, t1);
      chk("cfg_done_count2", cfg_done_n, 2);

      eval(4'd15);
      eval(4'd0);
      tick();
      tick();
      chk("ones_held", ones_count, {5'd1, 5'd8});
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_lut_eval.md
Name: prog_lut_eval

Overview:
- Parametrised, programmable N-input boolean function evaluator with N_OUT independent output channels.
- A truth table is loaded serially, then evaluated either per request (valid/ready) or by an automatic exhaustive sweep of all 2^N_IN input combinations.
- Sits between a config source and a checker/scoreboard; replaces fixed combinational function blocks with one reusable sequential block.

Parameters:
- N_IN, 4, number of function inputs; table depth DEPTH = 2^N_IN (N_IN 1..8).
- N_OUT, 1, number of independent output channels (one table per channel).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  pulse: begin table load (IDLE only)
- cfg_valid  in  1  one table bit per channel present on cfg_bit
- cfg_bit  in  N_OUT  table bit for current index, bit k = channel k
- cfg_done  out  1  one-cycle pulse after last table bit written
- in_valid  in  1  evaluation request
- in_vec  in  N_IN  input combination
- in_ready  out  1  request accepted when in_valid && in_ready
- sweep_start  in  1  pulse: begin exhaustive sweep (IDLE only)
- sweep_busy  out  1  high while in SWEEP
- sweep_done  out  1  one-cycle pulse after last sweep result accepted
- out_valid  out  1  result present
- out_idx  out  N_IN  input combination that produced out_vec
- out_vec  out  N_OUT  function result, bit k = table_k[out_idx]
- out_ready  in  1  result consumed when out_valid && out_ready
- ones_count  out  N_OUT*(N_IN+1)  per-channel count of 1 results in last sweep, channel k in slice k

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all tables 0; load pointer 0; sweep counter 0; out_valid 0, out_idx 0, out_vec 0; cfg_done 0, sweep_done 0, sweep_busy 0; ones_count 0; in_ready 0 during reset, 1 in the first cycle after reset.
- States: IDLE, LOAD, SWEEP.
- IDLE priority on the same cycle: cfg_start > sweep_start > in_valid. Lower-priority events are ignored/not accepted; in_ready is 0 whenever cfg_start or sweep_start is high.
- cfg_start and sweep_start are ignored outside IDLE. sweep_start is also ignored while out_valid=1.
- LOAD:
  - Each cycle with cfg_valid=1 writes cfg_bit[k] to table_k[ptr], then ptr++. Index order ascending from 0; cfg_valid=0 cycles stall.
  - On the write with ptr = DEPTH-1: ptr wraps to 0, next state IDLE, cfg_done=1 for exactly one cycle.
  - in_valid and starts are ignored during LOAD.
- Eval (IDLE):
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !cfg_start && !sweep_start.
  - On accept, next cycle: out_valid=1, out_idx=in_vec, out_vec[k]=table_k[in_vec]. Latency 1 cycle.
  - Back-to-back accepts give one result per cycle under out_ready=1.
  - Outputs are held stable while out_valid && !out_ready.
- SWEEP:
  - Counter i runs 0..DEPTH-1. Results are presented as out_idx=i, out_vec=table[i], one per cycle while out_ready=1.
  - On out_ready=0, the current result holds and i does not advance.
  - ones_count is cleared on sweep entry and accumulates out_vec bits on each accepted result; width N_IN+1 so a count of DEPTH cannot overflow.
  - After the result for i=DEPTH-1 is accepted: out_valid=0, state IDLE, sweep_done=1 for one cycle.
  - ones_count is held until the next sweep_start or reset.
- Table writes never occur outside LOAD. Evaluating an unloaded table returns 0.
- Reset mid-LOAD or mid-SWEEP: immediate abort, all state per the reset list; no done pulse.

Decomposition:
- Package prog_lut_pkg: state enum (IDLE, LOAD, SWEEP); helper function depth(n)=1<<n; default parameter constants.
- Sub-module prog_lut_table: DEPTH x N_OUT storage, one write port (addr, wdata, we), one combinational read port, async active-low clear.
- Top holds the FSM, pointer/counter, output register and ones counters.

Test Plan:
- Reset: assert rst_n=0 mid-run -> all outputs 0; first cycle after release in_ready=1, out_valid=0.
- Load parity table (N_IN=4, N_OUT=1, bits of 16'h6996 LSB first, with 3 cfg_valid gaps) -> cfg_done pulses once after 16th bit. Eval in_vec=4'b1011 -> next cycle out_vec=1, out_idx=11. Eval 4'b0011 -> 0.
- Backpressure: out_ready=0 while 3 requests are offered -> only first accepted, outputs frozen, in_ready=0; release -> remaining two results in order, one per cycle.
- Sweep on parity table with out_ready toggling 1/0 -> 16 results idx 0..15 matching 16'h6996, sweep_done once, ones_count=8.
- Two channels (N_OUT=2, table1 = AND of all inputs, i.e. only bit 15 set) -> sweep ones_count slices {ch0=8, ch1=1}.
- Same-cycle cfg_start+sweep_start+in_valid in IDLE -> LOAD entered, no sweep_busy, in_ready=0, no result produced.
